// File: rtl/apb4_ram_slave_pkg.sv
// Shared types and constants for the APB4 RAM completer and its environment.
package apb4_ram_slave_pkg;

    typedef enum logic {S_IDLE, S_ACCESS} apb_slv_state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_DEPTH  = 256;

    // Byte-lane strobe patterns for a 32-bit bus.
    localparam logic [3:0] PSTRB_NONE  = 4'h0;
    localparam logic [3:0] PSTRB_B0    = 4'h1;
    localparam logic [3:0] PSTRB_B1    = 4'h2;
    localparam logic [3:0] PSTRB_B2    = 4'h4;
    localparam logic [3:0] PSTRB_B3    = 4'h8;
    localparam logic [3:0] PSTRB_B0_B2 = 4'h5;
    localparam logic [3:0] PSTRB_ALL   = 4'hF;

endpackage

// File: rtl/apb4_ram_slave_mem.sv
// Word-organised RAM with a synchronous byte-enable write port and an asynchronous read port.
module apb4_ram_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] strb,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(STRB_WIDTH); k++) begin
                if (strb[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb4_ram_slave.sv
// APB4 completer in front of a byte-addressable RAM: wait states, byte-lane writes, PSLVERR decode.
module apb4_ram_slave
    import apb4_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRIV_BASE   = MEM_DEPTH,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
    localparam int unsigned WCNT_W   = 4;

    apb_slv_state_e        state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we_c;
    logic                  err_c;
    logic                  unused_pprot;

    assign idx          = PADDR[ADDR_LSB +: IDX_W];
    assign unused_pprot = ^PPROT[2:1];

    // Any address bit above the RAM's byte span means out of range (depth is a power of two).
    assign err_c = (|(PADDR >> (ADDR_LSB + IDX_W)))
                 || ((PADDR & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0)
                 || (!PWRITE && (PSTRB != '0))
                 || ((32'(idx) >= PRIV_BASE) && !PPROT[0]);

    apb4_ram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (mem_we_c),
        .idx   (idx),
        .wdata (PWDATA),
        .strb  (PSTRB),
        .rdata (mem_rdata)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        slverr_d = slverr_q;
        rdata_d  = rdata_q;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = S_ACCESS;
                    wcnt_d   = WCNT_W'(WAIT_STATES);
                    slverr_d = err_c;
                    rdata_d  = (!PWRITE && !err_c) ? mem_rdata : '0;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else if (PENABLE) begin
                    // Error was latched at setup; inputs are stable so it still applies here.
                    mem_we_c = PWRITE && !slverr_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign PREADY  = (state_q == S_ACCESS) && (wcnt_q == '0);
    assign PRDATA  = rdata_q;
    assign PSLVERR = slverr_q;

endmodule
